// File: rtl/sl_preceptron_data_packer.sv
// ----------------------------------------------------------------------------
// sl_preceptron_data_packer
//
// Upstream feeder for sl_preceptron_top. Collects one byte-serial vector from
// a valid/ready stream and stores it in a single buffer. Then it replays the
// vector as one gap-free data_valid burst of DATA_IN_LANES-wide words. Vectors
// whose length is not VECTOR_LENGTH are discarded and flagged on o_err_len.
//
// State table:
//   S_FILL     | accepting elements into the buffer (o_s_ready=1)
//   S_WAIT_DST | full vector buffered, waiting for i_dst_ready
//   S_DRAIN    | emitting buffer words, one per cycle, then o_vec_done
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_s_valid    input element valid
//   o_s_ready    packer can accept an element (S_FILL and not in reset)
//   i_s_data     input element, unsigned
//   i_s_last     last element of a vector, qualified by valid && ready
//   i_dst_ready  downstream MAC idle; a burst may start
//   o_data_valid burst word valid (registered)
//   o_data_in    burst word; lane 0 (first element) in the LSBs; 0 when idle
//   o_vec_done   one-cycle pulse after the last burst word
//   o_err_len    one-cycle pulse when a vector is discarded
//   o_vec_count  bursts emitted since reset, wraps
// ----------------------------------------------------------------------------
module sl_preceptron_data_packer #(
  parameter int DATA_IN_LANES = 4,
  parameter int DATA_IN_WIDTH = 8,
  parameter int VECTOR_LENGTH = 128,
  parameter int VEC_CNT_WIDTH = 16
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_s_valid,
  output logic                                   o_s_ready,
  input  logic [DATA_IN_WIDTH-1:0]               i_s_data,
  input  logic                                   i_s_last,
  input  logic                                   i_dst_ready,
  output logic                                   o_data_valid,
  output logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] o_data_in,
  output logic                                   o_vec_done,
  output logic                                   o_err_len,
  output logic [VEC_CNT_WIDTH-1:0]               o_vec_count
);

  localparam int WORD_W    = DATA_IN_LANES * DATA_IN_WIDTH;
  localparam int NUM_WORDS = VECTOR_LENGTH / DATA_IN_LANES;
  localparam int ELEM_W    = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
  localparam int WADDR_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
  localparam int LANE_W    = (DATA_IN_LANES > 1) ? $clog2(DATA_IN_LANES) : 1;

  localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(VECTOR_LENGTH - 1);
  localparam logic [WCNT_W-1:0] WORD_END  = WCNT_W'(NUM_WORDS);

  typedef enum logic [1:0] {
    S_FILL     = 2'd0,
    S_WAIT_DST = 2'd1,
    S_DRAIN    = 2'd2
  } state_t;

  state_t                     r_state;
  logic [ELEM_W-1:0]          r_elem_cnt;
  logic [WCNT_W-1:0]          r_word_cnt;
  logic                       r_dropping;
  logic                       r_data_valid;
  logic [WORD_W-1:0]          r_data_in;
  logic                       r_vec_done;
  logic                       r_err_len;
  logic [VEC_CNT_WIDTH-1:0]   r_vec_count;

  // Single vector buffer; contents are don't-care after reset, so no reset.
  logic [WORD_W-1:0]          r_buf [NUM_WORDS];

  logic                       w_s_ready;
  logic                       w_xfer;
  logic                       w_store;
  logic [WADDR_W-1:0]         w_word_idx;
  logic [LANE_W-1:0]          w_lane_idx;
  logic [WORD_W-1:0]          w_rd_word;

  assign w_s_ready  = (r_state == S_FILL) && !i_rst;
  assign w_xfer     = w_s_ready && i_s_valid;
  // Elements of an over-long vector past the error point are accepted but not stored.
  assign w_store    = w_xfer && !r_dropping;
  assign w_word_idx = WADDR_W'(r_elem_cnt / ELEM_W'(DATA_IN_LANES));
  assign w_lane_idx = LANE_W'(r_elem_cnt % ELEM_W'(DATA_IN_LANES));
  assign w_rd_word  = r_buf[r_word_cnt[WADDR_W-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_store) begin
      r_buf[w_word_idx][int'(w_lane_idx)*DATA_IN_WIDTH +: DATA_IN_WIDTH] <= i_s_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_FILL;
      r_elem_cnt   <= '0;
      r_word_cnt   <= '0;
      r_dropping   <= 1'b0;
      r_data_valid <= 1'b0;
      r_data_in    <= '0;
      r_vec_done   <= 1'b0;
      r_err_len    <= 1'b0;
      r_vec_count  <= '0;
    end else begin
      r_vec_done <= 1'b0;
      r_err_len  <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_xfer) begin
            if (r_dropping) begin
              // Tail of an over-long vector: swallow silently up to its s_last.
              if (i_s_last) begin
                r_dropping <= 1'b0;
              end
            end else if (r_elem_cnt == ELEM_LAST) begin
              r_elem_cnt <= '0;
              if (i_s_last) begin
                r_state <= S_WAIT_DST;
              end else begin
                r_err_len  <= 1'b1;
                r_dropping <= 1'b1;
              end
            end else if (i_s_last) begin
              r_err_len  <= 1'b1;
              r_elem_cnt <= '0;
            end else begin
              r_elem_cnt <= r_elem_cnt + ELEM_W'(1);
            end
          end
        end

        S_WAIT_DST: begin
          if (i_dst_ready) begin
            r_state    <= S_DRAIN;
            r_word_cnt <= '0;
          end
        end

        S_DRAIN: begin
          // dst_ready is not looked at here: the MAC needs the burst unbroken.
          if (r_word_cnt == WORD_END) begin
            r_data_valid <= 1'b0;
            r_data_in    <= '0;
            r_vec_done   <= 1'b1;
            r_vec_count  <= r_vec_count + VEC_CNT_WIDTH'(1);
            r_state      <= S_FILL;
          end else begin
            r_data_valid <= 1'b1;
            r_data_in    <= w_rd_word;
            r_word_cnt   <= r_word_cnt + WCNT_W'(1);
          end
        end

        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

  assign o_s_ready    = w_s_ready;
  assign o_data_valid = r_data_valid;
  assign o_data_in    = r_data_in;
  assign o_vec_done   = r_vec_done;
  assign o_err_len    = r_err_len;
  assign o_vec_count  = r_vec_count;

endmodule

// File: tb/tb_sl_preceptron_data_packer.sv
// ----------------------------------------------------------------------------
// tb_sl_preceptron_data_packer
//
// Randomized bench for sl_preceptron_data_packer. Each vector sent is turned
// into its expected burst words (or an expected length error) by a plain
// arithmetic model; a negedge monitor checks every burst word and pulse.
// ----------------------------------------------------------------------------
module tb_sl_preceptron_data_packer;

  localparam int LANES  = 4;
  localparam int WIDTH  = 8;
  localparam int VLEN   = 128;
  localparam int NWORDS = VLEN / LANES;
  localparam int CNTW   = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   s_valid = 1'b0;
  logic                   s_last = 1'b0;
  logic [WIDTH-1:0]       s_data = '0;
  logic                   dst_ready = 1'b0;
  logic                   s_ready;
  logic                   data_valid;
  logic [LANES*WIDTH-1:0] data_in;
  logic                   vec_done;
  logic                   err_len;
  logic [CNTW-1:0]        vec_count;

  sl_preceptron_data_packer #(
    .DATA_IN_LANES(LANES),
    .DATA_IN_WIDTH(WIDTH),
    .VECTOR_LENGTH(VLEN),
    .VEC_CNT_WIDTH(CNTW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_s_valid   (s_valid),
    .o_s_ready   (s_ready),
    .i_s_data    (s_data),
    .i_s_last    (s_last),
    .i_dst_ready (dst_ready),
    .o_data_valid(data_valid),
    .o_data_in   (data_in),
    .o_vec_done  (vec_done),
    .o_err_len   (err_len),
    .o_vec_count (vec_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  logic [31:0] exp_words[$];
  int          exp_err = 0;
  int          t_trig  = 0;

  // Monitor state
  int          run = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          burst_cnt = 0;
  int          last_err_cyc = -1;
  int          last_start_cyc = -1;
  logic [31:0] first_word = '0;
  logic [31:0] last_word = '0;
  bit          prev_valid = 1'b0;
  bit          mon_fall;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      run        = 0;
      prev_valid = 1'b0;
    end else begin
      if (data_valid) begin
        if (!prev_valid) begin
          last_start_cyc = cyc;
          first_word     = data_in;
        end
        last_word = data_in;
        run++;
        if (exp_words.size() == 0) check("word_unexpected", 1, 0);
        else check("burst_word", data_in, exp_words.pop_front());
      end else begin
        check("data_in_idle_zero", data_in, 0);
      end
      mon_fall = prev_valid && !data_valid;
      if (mon_fall) begin
        check("burst_len", run, NWORDS);
        run = 0;
        burst_cnt++;
      end
      if (mon_fall || vec_done) begin
        check("done_align", vec_done, mon_fall);
        check("ready_at_done", s_ready, 1);
      end
      if (vec_done) done_cnt++;
      if (err_len) begin
        err_cnt++;
        last_err_cyc = cyc;
      end
      if (err_len && vec_done) check("err_done_excl", 1, 0);
      prev_valid = data_valid;
    end
  end

  // Sends n elements with s_last on the final one; called right after a negedge.
  task automatic send_vec(input int n, input bit seq, input int gap_pct);
    logic [7:0]  el[$];
    logic [31:0] w;
    int          guard;
    for (int k = 0; k < n; k++) el.push_back(seq ? 8'(k) : 8'($urandom_range(0, 255)));
    if (n == VLEN) begin
      for (int j = 0; j < NWORDS; j++) begin
        w = '0;
        for (int l = 0; l < LANES; l++) w = w | (32'(el[j*LANES+l]) << (WIDTH*l));
        exp_words.push_back(w);
      end
    end else begin
      exp_err++;
    end
    for (int k = 0; k < n; k++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = el[k];
      s_last  = (k == n - 1);
      guard   = 0;
      while (!s_ready && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 500) begin
        check("s_ready_timeout", 0, 1);
        $fatal(1, "stopping: s_ready never rose");
      end
      if ((n < VLEN && k == n - 1) || (n >= VLEN && k == VLEN - 1)) t_trig = cyc + 1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int g = 0;
    while (done_cnt < target && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check(tag, done_cnt >= target, 1);
    repeat (2) @(negedge clk);
  endtask

  int t_basic, t_rise, e0, b0, d0, target, n;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_data_in", data_in, 0);
    check("rst_vec_count", vec_count, 0);
    check("rst_pulses", {vec_done, err_len}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", s_ready, 1);

    // Basic vector: elements 0..127, downstream already idle
    dst_ready = 1'b1;
    send_vec(VLEN, 1'b1, 0);
    t_basic = t_trig;
    wait_done(1, "basic_done");
    check("basic_first_word", first_word, 32'h03020100);
    check("basic_last_word", last_word, 32'h7F7E7D7C);
    check("basic_latency", last_start_cyc, t_basic + 2);
    check("basic_vec_count", vec_count, 1);

    // Backpressure: random fill gaps, downstream busy for 20 cycles
    dst_ready = 1'b0;
    send_vec(VLEN, 1'b0, 40);
    for (int i = 0; i < 20; i++) begin
      check("wait_s_ready", s_ready, 0);
      check("wait_data_valid", data_valid, 0);
      @(negedge clk);
    end
    dst_ready = 1'b1;
    t_rise = cyc;
    @(negedge clk);
    dst_ready = 1'b0;
    wait_done(2, "bp_done");
    check("bp_start", last_start_cyc, t_rise + 2);
    check("bp_vec_count", vec_count, 2);

    // Short vector then a good one
    dst_ready = 1'b1;
    e0 = err_cnt;
    b0 = burst_cnt;
    send_vec(100, 1'b0, 20);
    @(negedge clk);
    check("short_err_cnt", err_cnt, e0 + 1);
    check("short_err_time", last_err_cyc, t_trig);
    check("short_no_burst", burst_cnt, b0);
    check("short_ready", s_ready, 1);
    send_vec(VLEN, 1'b0, 20);
    wait_done(3, "short_next_done");
    check("short_vec_count", vec_count, 3);

    // Long vector (140) then a good one
    e0 = err_cnt;
    b0 = burst_cnt;
    send_vec(140, 1'b0, 0);
    @(negedge clk);
    check("long_err_cnt", err_cnt, e0 + 1);
    check("long_err_time", last_err_cyc, t_trig);
    check("long_no_burst", burst_cnt, b0);
    send_vec(VLEN, 1'b0, 10);
    wait_done(4, "long_next_done");
    check("long_single_err", err_cnt, e0 + 1);
    check("long_vec_count", vec_count, 4);

    // Random mix of lengths
    target = 4;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0:       n = $urandom_range(1, VLEN - 1);
        1:       n = VLEN;
        default: n = $urandom_range(VLEN + 1, VLEN + 40);
      endcase
      send_vec(n, 1'b0, 25);
      if (n == VLEN) target++;
    end
    wait_done(target, "mix_done");
    check("mix_err_total", err_cnt, exp_err);
    check("mix_vec_count", vec_count, target);
    check("mix_words_left", exp_words.size(), 0);

    // Reset in the 10th burst cycle
    send_vec(VLEN, 1'b0, 0);
    begin
      int g = 0;
      while (run < 10 && g < 300) begin
        @(negedge clk);
        #1;
        g++;
      end
      check("rst_mid_reach", run, 10);
    end
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", data_valid, 0);
    check("rst_mid_data", data_in, 0);
    check("rst_mid_count", vec_count, 0);
    check("rst_mid_ready", s_ready, 0);
    exp_words.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_no_done", done_cnt, d0);
    check("rst_mid_ready_after", s_ready, 1);

    // Five back-to-back vectors after reset
    for (int i = 0; i < 5; i++) send_vec(VLEN, 1'b0, 0);
    wait_done(d0 + 5, "b2b_done");
    check("b2b_vec_count", vec_count, 5);
    check("b2b_words_left", exp_words.size(), 0);
    check("final_err_total", err_cnt, exp_err);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sl_preceptron_data_packer.md
Name: sl_preceptron_data_packer

Overview:
- Upstream feeder for sl_preceptron_top.
- Accepts a byte-serial element stream over a valid/ready handshake with an end-of-vector marker.
- Buffers one complete vector and packs it into DATA_IN_LANES-wide words.
- Emits each vector as one contiguous data_valid burst, which the MAC datapath requires.
- Discards vectors whose length does not equal VECTOR_LENGTH and flags them.

Parameters:
- DATA_IN_LANES, 4, elements packed per output word.
- DATA_IN_WIDTH, 8, bits per element.
- VECTOR_LENGTH, 128, elements per vector. Must be a multiple of DATA_IN_LANES.
- VEC_CNT_WIDTH, 16, width of the accepted-vector counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input element valid.
- s_ready  out  1  packer can accept an element.
- s_data  in  DATA_IN_WIDTH  input element, unsigned.
- s_last  in  1  marks the final element of a vector; qualified by s_valid&&s_ready.
- dst_ready  in  1  level from control: downstream MAC idle, a burst may start.
- data_valid  out  1  drives sl_preceptron_top data_valid.
- data_in  out  DATA_IN_LANES*DATA_IN_WIDTH  drives sl_preceptron_top data_in.
- vec_done  out  1  one-cycle pulse when a burst completes.
- err_len  out  1  one-cycle pulse when a vector is discarded.
- vec_count  out  VEC_CNT_WIDTH  number of bursts emitted since reset; wraps.

Behaviour:
- Reset (async, active-high):
  - State FILL; element and word counters cleared; buffer contents don't-care.
  - data_valid=0, data_in=0, vec_done=0, err_len=0, vec_count=0.
  - s_ready=0 while rst is high; s_ready=1 from the first cycle after release.
- Reset mid-burst or mid-fill aborts immediately; the partial vector is lost and no vec_done is issued.
- Buffer: VECTOR_LENGTH/DATA_IN_LANES words of DATA_IN_LANES*DATA_IN_WIDTH bits (default 32x32).
- Packing order: element k goes to word k/LANES, lane k%LANES. Lane 0 occupies bits [DATA_IN_WIDTH-1:0], i.e. the first-received element sits in the LSBs.
- s_ready = (state==FILL) && !rst. A transfer occurs on a rising edge with s_valid&&s_ready.
- State FILL:
  - Each transfer writes s_data into the buffer at elem_cnt, then increments elem_cnt.
  - Transfer with s_last=1 and elem_cnt==VECTOR_LENGTH-1: go to WAIT_DST; elem_cnt clears.
  - Transfer with s_last=1 and elem_cnt<VECTOR_LENGTH-1 (short vector): err_len pulses next cycle; elem_cnt clears; stay in FILL.
  - Transfer with s_last=0 and elem_cnt==VECTOR_LENGTH-1 (long vector): err_len pulses next cycle; elem_cnt clears; stay in FILL. All further elements up to and including the next s_last are dropped (s_ready stays 1) without a second err_len.
- State WAIT_DST:
  - s_ready=0.
  - On an edge with dst_ready=1, go to DRAIN and clear word_cnt.
  - dst_ready=0 holds WAIT_DST indefinitely.
- State DRAIN:
  - Registered outputs: data_valid=1 and data_in=buffer[word_cnt] for exactly VECTOR_LENGTH/LANES consecutive cycles, with no gaps.
  - dst_ready is ignored once DRAIN is entered.
  - After the last word, the next cycle has data_valid=0, data_in=0, vec_done=1 and vec_count+1; state returns to FILL and s_ready=1 in that same cycle.
- data_in is 0 whenever data_valid=0.
- Latency: the first data_valid appears 1 cycle after the edge that samples dst_ready=1 in WAIT_DST. Minimum from the last-element transfer to the first data_valid is 2 cycles.
- Throughput: one element per cycle in FILL; no input acceptance during WAIT_DST/DRAIN (single buffer).
- vec_count wraps from 2^VEC_CNT_WIDTH-1 to 0.
- err_len and vec_done never assert in the same cycle.

Test Plan:
- Basic vector:
  - Stimulus: after reset, send elements 0..127 with s_last on 127, dst_ready=1.
  - Required: 32 contiguous data_valid cycles; first data_in=0x03020100, last 0x7F7E7D7C; vec_done pulse; vec_count=1.
- Backpressure and gaps:
  - Stimulus: s_valid toggled randomly during fill; dst_ready held 0 for 20 cycles after the last element.
  - Required: s_ready=0 and data_valid=0 for those 20 cycles; the burst then starts 1 cycle after dst_ready rises, with identical contents.
- Short vector:
  - Stimulus: s_last on element 99, then a valid 128-element vector.
  - Required: one err_len pulse, no data_valid for the short vector; the second vector is emitted intact; vec_count=1.
- Long vector:
  - Stimulus: 140 elements with s_last on 139, then a valid vector.
  - Required: one err_len pulse at element 127; elements 128..139 dropped; the following vector is emitted correctly.
- Reset mid-burst:
  - Stimulus: assert rst at the 10th data_valid cycle.
  - Required: data_valid and data_in go to 0 asynchronously; no vec_done; vec_count=0; the next full vector works.
- Five back-to-back vectors:
  - Stimulus: the same vectors as the top-level stimulus files, through packer plus sl_preceptron_top.
  - Required: status_ai_sum and status_ai_comparator match the expected file for all 5; vec_count=5.
